// File: rtl/pixel_combinator_if.sv
// Queue-side broadcast/pop bus plus the outgoing pixel stream of the combinator.
// master = combinator side, slave = queues + video sink side.
interface pixel_combinator_if #(
  parameter int NUM_ENGINES = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int RBG_SIZE    = 24
);
  logic [DATA_WIDTH-1:0]           xpixel_check;
  logic [DATA_WIDTH-1:0]           ypixel_check;
  logic [NUM_ENGINES-1:0]          q_hit;
  logic [NUM_ENGINES*RBG_SIZE-1:0] q_colour;
  logic [NUM_ENGINES-1:0]          q_pop;
  logic [RBG_SIZE-1:0]             out_data;
  logic                            out_valid;
  logic                            out_ready;
  logic                            out_sof;
  logic                            out_eol;

  modport master (
    output xpixel_check, ypixel_check, q_pop, out_data, out_valid, out_sof, out_eol,
    input  q_hit, q_colour, out_ready
  );

  modport slave (
    input  xpixel_check, ypixel_check, q_pop, out_data, out_valid, out_sof, out_eol,
    output q_hit, q_colour, out_ready
  );
endinterface

// File: rtl/pixel_combinator.sv
// Raster-order pixel collector: broadcasts the wanted (x,y), pops the lowest-index
// queue whose head matches, and emits the colour as a valid/ready stream with sof/eol.
module pixel_combinator #(
  parameter int NUM_ENGINES = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int RBG_SIZE    = 24,
  parameter int X_SIZE      = 640,
  parameter int Y_SIZE      = 480,
  parameter int STALL_LIMIT = 4096
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  pixel_combinator_if.master bus,
  output logic               busy,
  output logic               frame_done,
  output logic               dup_err,
  output logic               stall_err
);
  localparam int XW = (X_SIZE > 1) ? $clog2(X_SIZE) : 1;
  localparam int YW = (Y_SIZE > 1) ? $clog2(Y_SIZE) : 1;
  localparam int SW = (STALL_LIMIT > 1) ? $clog2(STALL_LIMIT) : 1;

  typedef enum logic [1:0] {IDLE, SEARCH, OUTPUT, DONE} state_t;
  state_t state, state_nxt;

  logic [XW-1:0]          x;
  logic [YW-1:0]          y;
  logic [SW-1:0]          stall_cnt;
  logic [RBG_SIZE-1:0]    data_q;
  logic                   valid_q, sof_q, eol_q;
  logic [NUM_ENGINES-1:0] sel;
  logic [RBG_SIZE-1:0]    col;
  logic                   hit, multi, accept, x_last, y_last;

  // two's-complement trick isolates the lowest set hit bit
  assign sel    = bus.q_hit & (~bus.q_hit + NUM_ENGINES'(1));
  assign hit    = |bus.q_hit;
  assign multi  = |(bus.q_hit & (bus.q_hit - NUM_ENGINES'(1)));
  assign x_last = (x == XW'(X_SIZE - 1));
  assign y_last = (y == YW'(Y_SIZE - 1));
  assign accept = (state == OUTPUT) && valid_q && bus.out_ready;

  always_comb begin
    col = '0;
    for (int i = 0; i < NUM_ENGINES; i++)
      if (sel[i]) col = bus.q_colour[i*RBG_SIZE +: RBG_SIZE];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SEARCH;
      SEARCH:  if (hit) state_nxt = OUTPUT;
      OUTPUT:  if (accept) state_nxt = (x_last && y_last) ? DONE : SEARCH;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != IDLE);
    frame_done = (state == DONE);
    bus.q_pop  = (state == SEARCH) ? sel : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x         <= '0;
      y         <= '0;
      stall_cnt <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      sof_q     <= 1'b0;
      eol_q     <= 1'b0;
      dup_err   <= 1'b0;
      stall_err <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          x <= '0;
          y <= '0;
        end
        SEARCH: if (hit) begin
          data_q    <= col;
          valid_q   <= 1'b1;
          sof_q     <= (x == '0) && (y == '0);
          eol_q     <= x_last;
          stall_cnt <= '0;
          if (multi) dup_err <= 1'b1;
        end else if (stall_cnt == SW'(STALL_LIMIT - 1)) begin
          stall_err <= 1'b1;
        end else begin
          stall_cnt <= stall_cnt + SW'(1);
        end
        OUTPUT: if (accept) begin
          valid_q <= 1'b0;
          sof_q   <= 1'b0;
          eol_q   <= 1'b0;
          if (x_last) begin
            x <= '0;
            y <= y_last ? '0 : y + YW'(1);
          end else begin
            x <= x + XW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.xpixel_check = DATA_WIDTH'(x);
  assign bus.ypixel_check = DATA_WIDTH'(y);
  assign bus.out_data     = data_q;
  assign bus.out_valid    = valid_q;
  assign bus.out_sof      = sof_q;
  assign bus.out_eol      = eol_q;
endmodule

// File: tb/tb_pixel_combinator.sv
// Directed frame sequence with random hit masks, colours, stalls and backpressure,
// checked against a raster-order pixel model with sticky error tracking.
module tb_pixel_combinator;
  localparam int NE = 4, DW = 16, RW = 24, XS = 4, YS = 2, SL = 8;

  logic clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic busy, frame_done, dup_err, stall_err;
  int   errors = 0, checks = 0;
  int   mx = 0, my = 0, nohit_run = 0;
  bit   exp_dup = 1'b0, exp_stall = 1'b0, ab;

  pixel_combinator_if #(.NUM_ENGINES(NE), .DATA_WIDTH(DW), .RBG_SIZE(RW)) bus ();

  pixel_combinator #(
    .NUM_ENGINES(NE), .DATA_WIDTH(DW), .RBG_SIZE(RW),
    .X_SIZE(XS), .Y_SIZE(YS), .STALL_LIMIT(SL)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .bus(bus.master),
    .busy(busy), .frame_done(frame_done), .dup_err(dup_err), .stall_err(stall_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // One pixel: optional no-hit cycles, a hit, optional backpressure, then accept.
  task automatic serve(input logic [NE-1:0] hit, input int stall, input int rdy_dly,
                       input bit abort, output bit aborted);
    logic [RW-1:0] colour;
    logic [NE-1:0] ep;
    int k;
    aborted = 1'b0;
    chk("x_check", bus.xpixel_check, mx);
    chk("y_check", bus.ypixel_check, my);
    for (int i = 0; i < stall; i++) begin
      bus.q_hit = '0;
      #1;
      chk("pop_nohit", bus.q_pop, 0);
      chk("valid_nohit", bus.out_valid, 0);
      tick();
      nohit_run++;
      if (nohit_run >= SL) exp_stall = 1'b1;
      chk("stall_err", stall_err, exp_stall);
    end
    for (int i = 0; i < NE; i++) bus.q_colour[i*RW +: RW] = RW'($urandom);
    bus.q_hit = hit;
    k = 0;
    for (int i = NE - 1; i >= 0; i--) if (hit[i]) k = i;
    colour = bus.q_colour[k*RW +: RW];
    ep = '0;
    ep[k] = 1'b1;
    #1;
    chk("pop_hit", bus.q_pop, ep);
    tick();
    bus.q_hit = '0;
    nohit_run = 0;
    if ($countones(hit) > 1) exp_dup = 1'b1;
    #1;
    chk("out_valid", bus.out_valid, 1);
    chk("out_data", bus.out_data, colour);
    chk("out_sof", bus.out_sof, (mx == 0 && my == 0));
    chk("out_eol", bus.out_eol, (mx == XS - 1));
    chk("pop_output", bus.q_pop, 0);
    chk("dup_err", dup_err, exp_dup);
    chk("stall_err_hit", stall_err, exp_stall);
    for (int i = 0; i < rdy_dly; i++) begin
      bus.out_ready = 1'b0;
      tick();
      chk("hold_valid", bus.out_valid, 1);
      chk("hold_data", bus.out_data, colour);
      chk("hold_x", bus.xpixel_check, mx);
      chk("hold_pop", bus.q_pop, 0);
    end
    if (abort) begin
      reset = 1'b1;
      #1;
      chk("abort_valid", bus.out_valid, 0);
      chk("abort_data", bus.out_data, 0);
      chk("abort_busy", busy, 0);
      chk("abort_x", bus.xpixel_check, 0);
      chk("abort_pop", bus.q_pop, 0);
      chk("abort_dup", dup_err, 0);
      tick();
      reset = 1'b0;
      chk("abort_done", frame_done, 0);
      mx = 0; my = 0; nohit_run = 0; exp_dup = 1'b0; exp_stall = 1'b0;
      aborted = 1'b1;
      return;
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("accept_valid", bus.out_valid, 0);
    if (mx == XS - 1 && my == YS - 1) begin
      chk("frame_done", frame_done, 1);
      tick();
      chk("frame_done_pulse", frame_done, 0);
      chk("idle_busy", busy, 0);
      mx = 0; my = 0;
    end else begin
      chk("no_frame_done", frame_done, 0);
      chk("busy", busy, 1);
      mx = (mx == XS - 1) ? 0 : mx + 1;
      if (mx == 0) my++;
    end
  endtask

  // kind 0: q0 only, no backpressure; 1: directed corners + start held high;
  // 2: random, reset mid-frame; 3: random full frame
  task automatic frame(input int kind);
    logic [NE-1:0] hit;
    int stall, rd;
    start = 1'b1;
    tick();
    if (kind != 1) start = 1'b0;
    chk("start_busy", busy, 1);
    for (int p = 0; p < XS * YS; p++) begin
      hit   = (kind == 0) ? NE'(1) : NE'($urandom_range(1, 15));
      stall = (kind == 0) ? 0 : $urandom_range(0, 2);
      rd    = (kind == 0) ? 0 : $urandom_range(0, 2);
      if (kind == 1 && p == 1) rd = 5;
      if (kind == 1 && p == 2) hit = 4'b0110;
      if (kind == 1 && p == 3) stall = 10;
      if (p == XS * YS - 1) start = 1'b0;
      serve(hit, stall, rd, (kind == 2 && p == 3), ab);
      if (ab) break;
    end
    start = 1'b0;
  endtask

  initial begin
    bus.q_hit = '0;
    bus.q_colour = '0;
    bus.out_ready = 1'b0;
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_x", bus.xpixel_check, 0);
    chk("rst_y", bus.ypixel_check, 0);
    chk("rst_pop", bus.q_pop, 0);
    chk("rst_errs", {dup_err, stall_err, frame_done}, 0);
    reset = 1'b0;
    tick();
    chk("idle_busy", busy, 0);
    frame(0);
    frame(1);
    chk("dup_sticky", dup_err, 1);
    chk("stall_sticky", stall_err, 1);
    tick();
    chk("no_restart", busy, 0);
    frame(2);
    frame(3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
